// File: rtl/bridge_pkg.sv
// Shared definitions for the bridge transmit path: class and credit-flag
// indices, the gate state encoding and the per-class eligibility helper.
package bridge_pkg;

    localparam int CLS_P   = 0;
    localparam int CLS_NP  = 1;
    localparam int CLS_CPL = 2;

    localparam int FC_PH   = 0;
    localparam int FC_PD   = 1;
    localparam int FC_NPH  = 2;
    localparam int FC_NPD  = 3;
    localparam int FC_CPLH = 4;
    localparam int FC_CPLD = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // A class may go only if its header credit, and data credit when it
    // carries a payload, are both flagged available on a live link.
    function automatic logic [2:0] cls_eligible(
        input logic [2:0] req,
        input logic [5:0] fc,
        input logic [2:0] has_data,
        input logic       link_up
    );
        logic [2:0] v;
        v[CLS_P]   = req[CLS_P]   & fc[FC_PH]   & (~has_data[CLS_P]   | fc[FC_PD]);
        v[CLS_NP]  = req[CLS_NP]  & fc[FC_NPH]  & (~has_data[CLS_NP]  | fc[FC_NPD]);
        v[CLS_CPL] = req[CLS_CPL] & fc[FC_CPLH] & (~has_data[CLS_CPL] | fc[FC_CPLD]);
        return v & {3{link_up}};
    endfunction

    function automatic logic [1:0] next_cls(input logic [1:0] c);
        return (c >= 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

endpackage

// File: rtl/bridge_rr_arb.sv
// Three-way round-robin picker: combinational one-hot select starting at the
// registered pointer, which moves past the winner when a grant is taken.
module bridge_rr_arb
    import bridge_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_req,
    input  logic       i_advance,
    output logic [2:0] o_sel
);

    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nx;
    logic [1:0] w_idx;
    logic       w_found;

    // First requesting class at or after the pointer, walking 0->1->2->0.
    always_comb begin
        o_sel    = 3'b000;
        w_ptr_nx = r_ptr;
        w_found  = 1'b0;
        w_idx    = r_ptr;
        for (int k = 0; k < 3; k++) begin
            if (!w_found && (w_idx != 2'd3) && i_req[w_idx]) begin
                o_sel[w_idx] = 1'b1;
                w_found      = 1'b1;
                w_ptr_nx     = next_cls(w_idx);
            end else begin
                w_found = w_found;
            end
            w_idx = next_cls(w_idx);
        end
    end

    // Pointer register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 2'd0;
        end else if (i_advance) begin
            r_ptr <= w_ptr_nx;
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/bridge_tx_gate.sv
// Transmit credit gate: grants one TLP class at a time against the flow-credit
// flags, tracks its beats, then settles so the flags can refresh.
module bridge_tx_gate
    import bridge_pkg::*;
#(
    parameter int BEAT_W      = 10,
    parameter int SETTLE_CYC  = 4,
    parameter int STALL_LIMIT = 1023
) (
    input  logic                Gate_CLK,
    input  logic                Gate_RST,
    input  logic                Gate_Link_Up,
    input  logic [5:0]          Gate_Tx_FC,
    input  logic [2:0]          Gate_Req,
    input  logic [2:0]          Gate_Has_Data,
    input  logic [3*BEAT_W-1:0] Gate_Beats,
    input  logic                Gate_Beat_Ack,
    output logic [2:0]          Gate_Grant,
    output logic                Gate_Busy,
    output logic                Gate_Done,
    output logic                Gate_Abort,
    output logic                Gate_Stall
);

    localparam int SET_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [SET_W-1:0]   SET_LAST  = SET_W'(SETTLE_CYC - 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);
    localparam logic [BEAT_W-1:0]  BEAT_ONE  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0]  BEAT_ZERO = {BEAT_W{1'b0}};

    state_t               r_state;
    state_t               w_next_state;
    logic [2:0]           w_elig;
    logic [2:0]           w_sel;
    logic                 w_take;
    logic                 w_last_ack;
    logic [BEAT_W-1:0]    w_beats_sel;
    logic [BEAT_W-1:0]    w_beats_load;
    logic [BEAT_W-1:0]    r_beat_cnt;
    logic [SET_W-1:0]     r_set_cnt;
    logic [STALL_W-1:0]   r_stall_cnt;
    logic [STALL_W-1:0]   w_stall_cnt_nx;
    logic [2:0]           w_grant_nx;
    logic                 w_done_nx;
    logic                 w_abort_nx;
    logic [2:0]           r_grant;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_abort;
    logic                 r_stall;

    assign w_elig     = cls_eligible(Gate_Req, Gate_Tx_FC, Gate_Has_Data, Gate_Link_Up);
    assign w_take     = (r_state == IDLE) && (w_elig != 3'b000);
    // A link drop in the same cycle as the final ack takes priority.
    assign w_last_ack = Gate_Link_Up && Gate_Beat_Ack && (r_beat_cnt == BEAT_ONE);

    bridge_rr_arb u_arb (
        .i_clk     (Gate_CLK),
        .i_rst     (Gate_RST),
        .i_req     (w_elig),
        .i_advance (w_take),
        .o_sel     (w_sel)
    );

    // Beat count of the selected class; zero-length packets count as one beat.
    always_comb begin
        case (w_sel)
            3'b001:  w_beats_sel = Gate_Beats[CLS_P   * BEAT_W +: BEAT_W];
            3'b010:  w_beats_sel = Gate_Beats[CLS_NP  * BEAT_W +: BEAT_W];
            3'b100:  w_beats_sel = Gate_Beats[CLS_CPL * BEAT_W +: BEAT_W];
            default: w_beats_sel = BEAT_ZERO;
        endcase
        if (w_beats_sel == BEAT_ZERO) begin
            w_beats_load = BEAT_ONE;
        end else begin
            w_beats_load = w_beats_sel;
        end
    end

    // State register.
    always_ff @(posedge Gate_CLK) begin
        if (Gate_RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decision.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_next_state = GRANT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            GRANT: begin
                if (!Gate_Link_Up) begin
                    w_next_state = IDLE;
                end else if (w_last_ack) begin
                    w_next_state = SETTLE;
                end else begin
                    w_next_state = GRANT;
                end
            end
            SETTLE: begin
                if (r_set_cnt == SET_LAST) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = SETTLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        w_done_nx  = (r_state == GRANT) && w_last_ack;
        w_abort_nx = (r_state == GRANT) && !Gate_Link_Up;
        case (r_state)
            IDLE:   w_grant_nx = w_sel;
            GRANT: begin
                if (!Gate_Link_Up || w_last_ack) begin
                    w_grant_nx = 3'b000;
                end else begin
                    w_grant_nx = r_grant;
                end
            end
            SETTLE:  w_grant_nx = 3'b000;
            default: w_grant_nx = 3'b000;
        endcase
    end

    // Stall counter: only credit blocking in IDLE advances it.
    always_comb begin
        w_stall_cnt_nx = r_stall_cnt;
        if (!Gate_Link_Up || (Gate_Req == 3'b000) || w_take) begin
            w_stall_cnt_nx = {STALL_W{1'b0}};
        end else if ((r_state == IDLE) && (r_stall_cnt != STALL_MAX)) begin
            w_stall_cnt_nx = r_stall_cnt + STALL_W'(1);
        end else begin
            w_stall_cnt_nx = r_stall_cnt;
        end
    end

    // Beat, settle and stall counters.
    always_ff @(posedge Gate_CLK) begin
        if (Gate_RST) begin
            r_beat_cnt  <= BEAT_ZERO;
            r_set_cnt   <= {SET_W{1'b0}};
            r_stall_cnt <= {STALL_W{1'b0}};
        end else begin
            r_stall_cnt <= w_stall_cnt_nx;
            case (r_state)
                IDLE: begin
                    r_set_cnt <= {SET_W{1'b0}};
                    if (w_take) begin
                        r_beat_cnt <= w_beats_load;
                    end else begin
                        r_beat_cnt <= r_beat_cnt;
                    end
                end
                GRANT: begin
                    r_set_cnt <= {SET_W{1'b0}};
                    if (Gate_Link_Up && Gate_Beat_Ack) begin
                        r_beat_cnt <= r_beat_cnt - BEAT_ONE;
                    end else begin
                        r_beat_cnt <= r_beat_cnt;
                    end
                end
                SETTLE: begin
                    r_set_cnt  <= r_set_cnt + SET_W'(1);
                    r_beat_cnt <= r_beat_cnt;
                end
                default: begin
                    r_set_cnt  <= {SET_W{1'b0}};
                    r_beat_cnt <= BEAT_ZERO;
                end
            endcase
        end
    end

    // Output registers.
    always_ff @(posedge Gate_CLK) begin
        if (Gate_RST) begin
            r_grant <= 3'b000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            r_stall <= 1'b0;
        end else begin
            r_grant <= w_grant_nx;
            r_busy  <= (w_next_state != IDLE);
            r_done  <= w_done_nx;
            r_abort <= w_abort_nx;
            r_stall <= (w_stall_cnt_nx == STALL_MAX);
        end
    end

    assign Gate_Grant = r_grant;
    assign Gate_Busy  = r_busy;
    assign Gate_Done  = r_done;
    assign Gate_Abort = r_abort;
    assign Gate_Stall = r_stall;

endmodule

// File: tb/tb_bridge_tx_gate.sv
// Scoreboard bench for bridge_tx_gate: a packet-level reference model queues
// every expected change of the output vector; a monitor pops and compares.
module tb_bridge_tx_gate;

    localparam int BEAT_W      = 10;
    localparam int SETTLE_CYC  = 4;
    localparam int STALL_LIMIT = 1023;

    logic                Gate_CLK;
    logic                Gate_RST;
    logic                Gate_Link_Up;
    logic [5:0]          Gate_Tx_FC;
    logic [2:0]          Gate_Req;
    logic [2:0]          Gate_Has_Data;
    logic [3*BEAT_W-1:0] Gate_Beats;
    logic                Gate_Beat_Ack;
    logic [2:0]          Gate_Grant;
    logic                Gate_Busy;
    logic                Gate_Done;
    logic                Gate_Abort;
    logic                Gate_Stall;

    bridge_tx_gate #(
        .BEAT_W      (BEAT_W),
        .SETTLE_CYC  (SETTLE_CYC),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .Gate_CLK      (Gate_CLK),
        .Gate_RST      (Gate_RST),
        .Gate_Link_Up  (Gate_Link_Up),
        .Gate_Tx_FC    (Gate_Tx_FC),
        .Gate_Req      (Gate_Req),
        .Gate_Has_Data (Gate_Has_Data),
        .Gate_Beats    (Gate_Beats),
        .Gate_Beat_Ack (Gate_Beat_Ack),
        .Gate_Grant    (Gate_Grant),
        .Gate_Busy     (Gate_Busy),
        .Gate_Done     (Gate_Done),
        .Gate_Abort    (Gate_Abort),
        .Gate_Stall    (Gate_Stall)
    );

    typedef struct {
        int         cyc;
        logic [6:0] vec;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   running  = 1'b1;

    // Reference model: phase 0 idle, 1 packet in flight, 2 settling.
    int         m_phase   = 0;
    int         m_gcls    = -1;
    int         m_left    = 0;
    int         m_settle  = 0;
    int         m_rr      = 0;
    int         m_blocked = 0;
    logic [6:0] m_prev    = 7'd0;

    initial begin
        Gate_CLK = 1'b0;
        forever #5 Gate_CLK = ~Gate_CLK;
    end

    function automatic bit eligible(int c, logic [2:0] req, logic [5:0] fc,
                                    logic [2:0] hd, logic link);
        return req[c] && fc[2*c] && (!hd[c] || fc[2*c+1]) && link;
    endfunction

    function automatic logic [29:0] bts(int b0, int b1, int b2);
        return {10'(b2), 10'(b1), 10'(b0)};
    endfunction

    task automatic model_step(input logic rst, input logic link, input logic [5:0] fc,
                              input logic [2:0] req, input logic [2:0] hd,
                              input logic [29:0] beats, input logic ack);
        bit         done_p  = 1'b0;
        bit         abort_p = 1'b0;
        bit         found   = 1'b0;
        int         c;
        logic [2:0] g;
        logic [6:0] v;
        exp_t       e;
        if (rst) begin
            m_phase = 0; m_gcls = -1; m_left = 0; m_settle = 0; m_rr = 0; m_blocked = 0;
        end else begin
            if (m_phase == 0) begin
                for (int k = 0; k < 3; k++) begin
                    c = (m_rr + k) % 3;
                    if (!found && eligible(c, req, fc, hd, link)) begin
                        found   = 1'b1;
                        m_gcls  = c;
                        m_left  = int'(beats[c*BEAT_W +: BEAT_W]);
                        if (m_left == 0) m_left = 1;
                        m_rr    = (c + 1) % 3;
                        m_phase = 1;
                    end
                end
                if (found || req == 3'b000 || !link) m_blocked = 0;
                else if (m_blocked < STALL_LIMIT) m_blocked++;
            end else begin
                if (m_phase == 1) begin
                    if (!link) begin
                        abort_p = 1'b1; m_gcls = -1; m_phase = 0;
                    end else if (ack) begin
                        m_left--;
                        if (m_left == 0) begin
                            done_p = 1'b1; m_gcls = -1; m_phase = 2; m_settle = SETTLE_CYC;
                        end
                    end
                end else begin
                    m_settle--;
                    if (m_settle == 0) m_phase = 0;
                end
                if (req == 3'b000 || !link) m_blocked = 0;
            end
        end
        g = 3'b000;
        if (m_gcls >= 0) g[m_gcls] = 1'b1;
        v = {g, m_phase != 0, done_p, abort_p, m_blocked == STALL_LIMIT};
        if (v != m_prev) begin
            e.cyc = cyc;
            e.vec = v;
            q.push_back(e);
            m_prev = v;
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model.
    task automatic step(input logic rst, input logic link, input logic [5:0] fc,
                        input logic [2:0] req, input logic [2:0] hd,
                        input logic [29:0] beats, input logic ack);
        Gate_RST      = rst;
        Gate_Link_Up  = link;
        Gate_Tx_FC    = fc;
        Gate_Req      = req;
        Gate_Has_Data = hd;
        Gate_Beats    = beats;
        Gate_Beat_Ack = ack;
        @(posedge Gate_CLK);
        cyc++;
        model_step(rst, link, fc, req, hd, beats, ack);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 6'h3F, 3'b000, 3'b000, 30'd0, 1'b0);
    endtask

    task automatic check_zero(input string name);
        logic [6:0] cur;
        cur = {Gate_Grant, Gate_Busy, Gate_Done, Gate_Abort, Gate_Stall};
        checks++;
        if (cur !== 7'd0) begin
            failures++;
            $display("FAIL %s: outputs=%b required=0000000", name, cur);
        end
    endtask

    // Monitor: every change of the observed output vector must match the queue head.
    initial begin
        logic [6:0] prev;
        logic [6:0] cur;
        exp_t       e;
        prev = 7'd0;
        while (running) begin
            @(negedge Gate_CLK);
            cur = {Gate_Grant, Gate_Busy, Gate_Done, Gate_Abort, Gate_Stall};
            if (cur !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change: cyc=%0d outputs=%b required=%b (no change)",
                             cyc, cur, prev);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || e.vec !== cur) begin
                        failures++;
                        $display("FAIL output_change: cyc=%0d outputs=%b required cyc=%0d outputs=%b",
                                 cyc, cur, e.cyc, e.vec);
                    end
                end
                prev = cur;
            end
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_change: cyc=%0d outputs=%b required cyc=%0d outputs=%b",
                         cyc, cur, e.cyc, e.vec);
            end
        end
    end

    initial begin
        logic [5:0]  fc;
        logic [2:0]  req;
        logic [2:0]  hd;
        logic [29:0] bt;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 6'h00, 3'b000, 3'b000, 30'd0, 1'b0);
        check_zero("reset_state");
        idle(2);

        // Single posted 3-beat packet.
        step(1'b0, 1'b1, 6'b000011, 3'b001, 3'b000, bts(3, 0, 0), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 6'b000011, 3'b000, 3'b000, 30'd0, 1'b1);
        idle(8);

        // All classes requesting: round-robin order with settle gaps.
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 6'h3F, 3'b111, 3'b111, bts(1, 2, 1), 1'b1);
        idle(8);

        // Non-posted blocked on data credit until the stall flag rises.
        for (int i = 0; i < STALL_LIMIT + 6; i++)
            step(1'b0, 1'b1, 6'b000100, 3'b010, 3'b010, bts(0, 2, 0), 1'b0);
        step(1'b0, 1'b1, 6'b001100, 3'b010, 3'b010, bts(0, 2, 0), 1'b0);
        step(1'b0, 1'b1, 6'b001100, 3'b000, 3'b000, 30'd0, 1'b1);
        step(1'b0, 1'b1, 6'b001100, 3'b000, 3'b000, 30'd0, 1'b1);
        idle(8);

        // Link drop after two acks of an 8-beat packet.
        step(1'b0, 1'b1, 6'h3F, 3'b001, 3'b001, bts(8, 0, 0), 1'b0);
        step(1'b0, 1'b1, 6'h3F, 3'b000, 3'b000, 30'd0, 1'b1);
        step(1'b0, 1'b1, 6'h3F, 3'b000, 3'b000, 30'd0, 1'b1);
        step(1'b0, 1'b0, 6'h3F, 3'b001, 3'b000, 30'd0, 1'b0);
        step(1'b0, 1'b0, 6'h3F, 3'b001, 3'b000, 30'd0, 1'b0);
        idle(3);

        // Zero-beat packet, then final ack coinciding with a link drop.
        step(1'b0, 1'b1, 6'h3F, 3'b100, 3'b000, bts(0, 0, 0), 1'b0);
        step(1'b0, 1'b1, 6'h3F, 3'b000, 3'b000, 30'd0, 1'b1);
        idle(7);
        step(1'b0, 1'b1, 6'h3F, 3'b010, 3'b000, bts(0, 0, 0), 1'b0);
        step(1'b0, 1'b0, 6'h3F, 3'b000, 3'b000, 30'd0, 1'b1);
        idle(3);

        // Reset in the middle of a packet, then pointer back at posted.
        step(1'b0, 1'b1, 6'h3F, 3'b010, 3'b000, bts(0, 5, 0), 1'b0);
        step(1'b0, 1'b1, 6'h3F, 3'b000, 3'b000, 30'd0, 1'b1);
        step(1'b1, 1'b1, 6'h3F, 3'b000, 3'b000, 30'd0, 1'b1);
        check_zero("reset_mid_grant");
        step(1'b0, 1'b1, 6'h3F, 3'b111, 3'b000, bts(1, 1, 1), 1'b0);
        step(1'b0, 1'b1, 6'h3F, 3'b000, 3'b000, 30'd0, 1'b1);
        idle(8);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 6; b++) fc[b] = ($urandom_range(0, 3) != 0);
            req = 3'($urandom_range(0, 7));
            hd  = 3'($urandom_range(0, 7));
            bt  = bts(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 5)));
            step($urandom_range(0, 999) < 3, $urandom_range(0, 99) < 97, fc, req, hd, bt,
                 $urandom_range(0, 1) == 1);
        end
        idle(12);

        @(negedge Gate_CLK);
        #1;
        running = 1'b0;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
